// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared definitions for the iterative InvMixColumns block: FSM encodings
// and GF(2^8) multiply-by-constant helpers (reduction polynomial 0x11B).
package inv_mix_columns_seq_pkg;

  // 2'd3 is not a legal state; the FSM falls back to IDLE from it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns on one 32-bit column, row 0 byte in the MSB.
module inv_mix_column_word
  import inv_mix_columns_seq_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Each output row uses the {0E,0B,0D,09} coefficients rotated by its row index.
  always_comb begin
    col_out[31:24] = gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3);
    col_out[23:16] = gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3);
    col_out[15:8]  = gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3);
    col_out[7:0]   = gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3);
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one column per clock through a single shared
// column unit, valid/ready on both sides, result held in DONE until taken.
module inv_mix_columns_seq
  import inv_mix_columns_seq_pkg::*;
#(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

  state_t       fsm, nxt;
  logic [1:0]   col;
  logic [127:0] st;
  logic [6:0]   base;
  logic [31:0]  cur_col, mixed_col;

  // Column col occupies st[127-32*col -: 32].
  assign base    = 7'd127 - {col, 5'd0};
  assign cur_col = st[base -: 32];

  inv_mix_column_word u_word (
    .col_in  (cur_col),
    .col_out (mixed_col)
  );

  assign out_state = st;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= nxt;
  end

  // Next state and handshake outputs; outputs depend on the state only.
  always_comb begin
    nxt       = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (col == LAST_COL) nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Capture in IDLE, rewrite one column per CALC cycle; col wraps to 0 on exit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= '0;
      col <= '0;
    end else if (fsm == IDLE && in_valid) begin
      st  <= in_state;
      col <= '0;
    end else if (fsm == CALC) begin
      st[base -: 32] <= mixed_col;
      col            <= col + 2'd1;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq.
module tb_inv_mix_columns_seq;

  localparam int NCOL = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;

  inv_mix_columns_seq #(.NCOL(NCOL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Encrypt-side MixColumns, used only to build round-trip stimulus.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_fwd(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < NCOL; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  // One transaction with out_ready held high; checks latency and result.
  task automatic do_tx(input string tag, input logic [127:0] s, input logic [127:0] exp);
    int n;
    in_state  = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'd5);
    chk(tag, out_state, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] orig;
    int a0;
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_state", out_state,       128'd0);
    chk("rst_busy",      128'(busy),      128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 round-1 vector.
    do_tx("fips", 128'h046681E5E0CB199A48F8D37A2806264C, 128'hD4BF5D30E0B452AEB84111F11E2798E5);
    do_tx("col8e", {4{32'h8E4DA1BC}}, {4{32'hDB135345}});
    do_tx("zero", 128'd0, 128'd0);
    do_tx("ones", {4{32'h01010101}}, {4{32'h01010101}});

    // Busy during CALC.
    in_state = {4{32'h8E4DA1BC}}; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("calc_busy", 128'(busy), 128'd1);
    chk("calc_in_ready", 128'(in_ready), 128'd0);
    a0 = 0;
    while (!out_valid && a0 < 20) begin
      @(posedge clk); #1;
      a0++;
    end
    chk("bp_result", out_state, {4{32'hDB135345}});
    // Backpressure with a competing in_valid.
    in_valid = 1'b1; in_state = 128'hFFFF_0000_1234_5678_9ABC_DEF0_0F0F_F0F0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_state", out_state, {4{32'hDB135345}});
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    chk("bp_ignored_busy", 128'(busy), 128'd0);

    // Back-to-back throughput.
    do_tx("b2b_a", 128'h046681E5E0CB199A48F8D37A2806264C, 128'hD4BF5D30E0B452AEB84111F11E2798E5);
    a0 = acc_cyc;
    do_tx("b2b_b", {4{32'h8E4DA1BC}}, {4{32'hDB135345}});
    chk("b2b_spacing", 128'(acc_cyc - a0), 128'd6);

    // Reset at col=2 aborts the operation.
    in_state = 128'h046681E5E0CB199A48F8D37A2806264C; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready",  128'(in_ready),  128'd1);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_out_state", out_state,       128'd0);
    a0 = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) a0++;
    end
    chk("abort_no_pulse", 128'(a0), 128'd0);
    do_tx("after_abort", 128'h046681E5E0CB199A48F8D37A2806264C, 128'hD4BF5D30E0B452AEB84111F11E2798E5);

    // Reset wins over a same-cycle in_valid.
    rst_n = 1'b0; in_valid = 1'b1; in_state = {4{32'h8E4DA1BC}};
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_vs_valid_state", out_state, 128'd0);
    @(posedge clk); #1;
    chk("rst_vs_valid_busy", 128'(busy), 128'd0);

    // Round trip through forward MixColumns.
    for (int i = 0; i < 100; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      do_tx("roundtrip", mix_fwd(orig), orig);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
